// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter.
// The instruction-fetch port (inst_*) and the load/store port (data_*) share
// one slave bus (ram_*). Ownership covers a whole cyc-bounded bus cycle, and
// the bus always passes through one IDLE cycle between owners. ack is routed
// only to the owner. An optional watchdog answers a hung slave with err.
module wb_arbiter2 #(
   parameter  int ADDR_W     = 32,
   parameter  int DATA_W     = 32,
   parameter  int FIXED_PRIO = 0,   // 0: round-robin on ties, 1: data wins ties
   parameter  int TIMEOUT    = 0,   // unacked strobe cycles before err, 0 = off
   localparam int SEL_W      = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   input  logic [SEL_W-1:0]  inst_sel,
   input  logic              inst_we,
   input  logic              inst_cyc,
   input  logic              inst_stb,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_ack,
   output logic              inst_err,

   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   input  logic [SEL_W-1:0]  data_sel,
   input  logic              data_we,
   input  logic              data_cyc,
   input  logic              data_stb,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_ack,
   output logic              data_err,

   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [SEL_W-1:0]  ram_sel,
   output logic              ram_we,
   output logic              ram_cyc,
   output logic              ram_stb,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   rr_data;        // 1 = data master was served last
   logic   rr_next;
   logic   own_cyc;        // owner's cyc, 0 when idle
   logic   own_stb;        // owner's stb, 0 when idle
   logic   expire;         // watchdog fires this cycle

   // Owner register and round-robin pointer.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      if (reset) begin
         state   <= IDLE;
         rr_data <= 1'b1;   // first tie after reset goes to inst
      end else begin
         state   <= state_next;
         rr_data <= rr_next;
      end
   end

   // Arbitration decision and owner-to-slave request mux.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_next = state;
      rr_next    = rr_data;
      own_cyc    = 1'b0;
      own_stb    = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      ram_sel    = '0;
      ram_we     = 1'b0;
      case (state)
         IDLE: begin
            // ram_ack is ignored here: a late ack from a released cycle sinks.
            if (inst_cyc && data_cyc) begin
               if ((FIXED_PRIO != 0) || !rr_data) begin
                  state_next = OWN_DATA;
                  rr_next    = 1'b1;
               end else begin
                  state_next = OWN_INST;
                  rr_next    = 1'b0;
               end
            end else if (inst_cyc) begin
               state_next = OWN_INST;
               rr_next    = 1'b0;
            end else if (data_cyc) begin
               state_next = OWN_DATA;
               rr_next    = 1'b1;
            end
         end
         OWN_INST: begin
            own_cyc   = inst_cyc;
            own_stb   = inst_stb;
            ram_addr  = inst_addr;
            ram_wdata = inst_wdata;
            ram_sel   = inst_sel;
            ram_we    = inst_we;
            if (!inst_cyc) state_next = IDLE;
         end
         OWN_DATA: begin
            own_cyc   = data_cyc;
            own_stb   = data_stb;
            ram_addr  = data_addr;
            ram_wdata = data_wdata;
            ram_sel   = data_sel;
            ram_we    = data_we;
            if (!data_cyc) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int CNT_W = $clog2(TIMEOUT + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

         logic [CNT_W-1:0] wd_cnt;
         logic             stb_pending;

         // A strobe is outstanding when the owner strobes and the slave is silent.
         assign stb_pending = own_cyc && own_stb && !ram_ack;
         // The TIMEOUT-th consecutive outstanding cycle expires; an ack wins.
         assign expire = stb_pending && (wd_cnt == CNT_LAST);

         // Count outstanding strobe cycles; the clear on expiry keeps it from wrapping.
         always_ff @(posedge clk) begin
            if (reset || !stb_pending || expire) wd_cnt <= '0;
            else                                 wd_cnt <= wd_cnt + CNT_W'(1);
         end
      end else begin : g_no_wd
         assign expire = 1'b0;
      end
   endgenerate

   // The expiry cycle withdraws the request from the slave.
   assign ram_cyc = own_cyc && !expire;
   assign ram_stb = own_stb && !expire;

   // Read data is broadcast; each master qualifies it with its own ack.
   assign inst_rdata = ram_rdata;
   assign data_rdata = ram_rdata;

   assign inst_ack = (state == OWN_INST) && ram_ack;
   assign data_ack = (state == OWN_DATA) && ram_ack;
   assign inst_err = (state == OWN_INST) && expire;
   assign data_err = (state == OWN_DATA) && expire;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: one round-robin instance with a 4-cycle watchdog and
// one fixed-priority instance without watchdog, each behind its own
// registered-ack RAM model. A table of per-cycle vectors drives both;
// expectations are queued as each vector is driven and compared mid-cycle.
module tb_wb_arbiter2;

   localparam logic [31:0] A_INST = 32'h0000_0010;
   localparam logic [31:0] A_DATA = 32'h0000_0020;
   localparam logic [31:0] WDATA  = 32'hDEAD_BEEF;
   localparam logic [3:0]  DSEL   = 4'b0011;
   localparam logic [31:0] R10    = 32'h1122_3344;  // word at 0x10
   localparam logic [31:0] RW     = 32'h5566_BEEF;  // 0x55667788 after the sel=0011 store

   logic clk = 1'b0;
   logic reset;
   logic inst_cyc, inst_stb, data_cyc, data_stb, data_we, stall;

   always #5 clk = ~clk;

   // Observed outputs of each instance, index 0 = round-robin, 1 = fixed priority.
   logic [1:0]       o_rc, o_rs, o_we, o_ia, o_da, o_ie, o_de;
   logic [1:0][31:0] o_ra, o_ird, o_drd;
   logic [1:0][3:0]  o_sel;

   generate
      for (genvar g = 0; g < 2; g++) begin : g_inst
         logic        rc, rs, rwe, ia, da, ie, de, sack;
         logic [31:0] ra, rwd, ird, drd, srd;
         logic [3:0]  rsel;
         logic [31:0] mem [16];

         wb_arbiter2 #(
            .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(g), .TIMEOUT(g == 0 ? 4 : 0)
         ) dut (
            .clk(clk), .reset(reset),
            .inst_addr(A_INST), .inst_wdata(32'h0), .inst_sel(4'hF), .inst_we(1'b0),
            .inst_cyc(inst_cyc), .inst_stb(inst_stb),
            .inst_rdata(ird), .inst_ack(ia), .inst_err(ie),
            .data_addr(A_DATA), .data_wdata(WDATA), .data_sel(DSEL), .data_we(data_we),
            .data_cyc(data_cyc), .data_stb(data_stb),
            .data_rdata(drd), .data_ack(da), .data_err(de),
            .ram_addr(ra), .ram_wdata(rwd), .ram_sel(rsel), .ram_we(rwe),
            .ram_cyc(rc), .ram_stb(rs), .ram_rdata(srd), .ram_ack(sack)
         );

         initial begin
            for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
            mem[4] = R10;
            mem[8] = 32'h5566_7788;
         end

         // RAM model: registered ack one cycle after an accepted strobe.
         always @(posedge clk) begin
            if (reset) begin
               sack <= 1'b0;
               srd  <= '0;
            end else begin
               sack <= rc && rs && !sack && !stall;
               if (rc && rs && !sack && !stall) begin
                  if (rwe) begin
                     for (int k = 0; k < 4; k++)
                        if (rsel[k]) mem[ra[5:2]][k*8 +: 8] <= rwd[k*8 +: 8];
                  end else begin
                     srd <= mem[ra[5:2]];
                  end
               end
            end
         end

         assign o_rc[g] = rc;   assign o_rs[g] = rs;   assign o_we[g] = rwe;
         assign o_ia[g] = ia;   assign o_da[g] = da;
         assign o_ie[g] = ie;   assign o_de[g] = de;
         assign o_ra[g] = ra;   assign o_sel[g] = rsel;
         assign o_ird[g] = ird; assign o_drd[g] = drd;
      end
   endgenerate

   typedef struct {
      logic        rst, ic, is, dc, ds, dwe, st;
      int          dut;                 // which instance is checked
      logic [1:0]  own;                 // 0 idle, 1 inst, 2 data
      logic        rc, rs, ia, da, ie, de;
      logic [31:0] rd;                  // 0 = read data not checked
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void add(input logic rst, ic, is, dc, ds, dwe, st, input int dut,
                               input logic [1:0] own, input logic rc, rs, ia, da, ie, de,
                               input logic [31:0] rd);
      vec_t v;
      v.rst = rst; v.ic = ic; v.is = is; v.dc = dc; v.ds = ds; v.dwe = dwe; v.st = st;
      v.dut = dut; v.own = own;
      v.rc = rc; v.rs = rs; v.ia = ia; v.da = da; v.ie = ie; v.de = de; v.rd = rd;
      vecs.push_back(v);
   endfunction

   task automatic check(input int row, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL row %0d %s: got %h, expected %h", row, name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench did not finish in time");
   end

   initial begin
      vec_t        e;
      logic [31:0] exp_ra, exp_rd;
      logic [3:0]  exp_sel;
      int          d;

      // ---- stimulus table: rst ic is dc ds we st dut | own rc rs ia da ie de rd
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);     // reset state
      // single fetch
      add(0, 1,1,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 1, 1,1,1,0,0,0, R10);
      add(0, 0,0,0,0,0,0, 0, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // round-robin tie out of reset, then data store and read-back
      add(1, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,1,1,1,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,1,1,1,0, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,1,1,1,0, 0, 1, 1,1,1,0,0,0, R10);
      add(0, 0,0,1,1,1,0, 0, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,1,1,1,0, 0, 0, 0,0,0,0,0,0, 0);     // forced IDLE between owners
      add(0, 0,0,1,1,1,0, 0, 2, 1,1,0,0,0,0, 0);
      add(0, 0,0,1,1,1,0, 0, 2, 1,1,0,1,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 2, 0,0,0,0,0,0, 0);
      add(0, 0,0,1,1,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 0,0,1,1,0,0, 0, 2, 1,1,0,0,0,0, 0);
      add(0, 0,0,1,1,0,0, 0, 2, 1,1,0,1,0,0, RW);
      add(0, 0,0,0,0,0,0, 0, 2, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // repeated ties alternate inst, data, inst
      add(1, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      for (int t = 0; t < 3; t++) begin
         logic [1:0] w;
         w = (t == 1) ? 2'd2 : 2'd1;
         add(0, 1,1,1,1,0,0, 0, 0, 0,0,0,0,0,0, 0);
         add(0, 1,1,1,1,0,0, 0, w, 1,1,0,0,0,0, 0);
         add(0, 1,1,1,1,0,0, 0, w, 1,1,w == 2'd1,w == 2'd2,0,0, 0);
         add(0, 0,0,0,0,0,0, 0, w, 0,0,0,0,0,0, 0);
      end
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // locked data burst with stb gaps, inst waiting throughout
      add(0, 0,0,1,1,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,1,0,0, RW);
      add(0, 1,1,1,0,0,0, 0, 2, 1,0,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,1,0,0, RW);
      add(0, 1,1,1,0,0,0, 0, 2, 1,0,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,1,0,0, RW);
      add(0, 1,1,0,0,0,0, 0, 2, 0,0,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 1, 1,1,1,0,0,0, R10);
      add(0, 0,0,0,0,0,0, 0, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // watchdog: stalled slave, err on the 4th unacked strobe cycle only
      add(0, 1,1,0,0,0,1, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 0,0,0,0,1,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // watchdog: ack arriving on the expiry cycle wins, no err
      add(0, 1,1,0,0,0,1, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,1, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 0, 1, 1,1,1,0,0,0, R10);
      add(0, 0,0,0,0,0,0, 0, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // reset while data owns with stb high
      add(0, 0,0,1,1,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 2, 1,1,0,0,0,0, 0);
      add(1, 1,1,1,1,0,0, 0, 2, 1,1,0,1,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,1,1,0,0, 0, 1, 1,1,1,0,0,0, R10);
      add(0, 0,0,0,0,0,0, 0, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 0, 0, 0,0,0,0,0,0, 0);
      // fixed priority instance: data wins every tie
      add(1, 0,0,0,0,0,0, 1, 0, 0,0,0,0,0,0, 0);
      for (int t = 0; t < 2; t++) begin
         add(0, 1,1,1,1,0,0, 1, 0, 0,0,0,0,0,0, 0);
         add(0, 1,1,1,1,0,0, 1, 2, 1,1,0,0,0,0, 0);
         add(0, 1,1,1,1,0,0, 1, 2, 1,1,0,1,0,0, 0);
         add(0, 1,1,0,0,0,0, 1, 2, 0,0,0,0,0,0, 0);
      end
      add(0, 1,1,0,0,0,0, 1, 0, 0,0,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 1, 1, 1,1,0,0,0,0, 0);
      add(0, 1,1,0,0,0,0, 1, 1, 1,1,1,0,0,0, R10);
      add(0, 0,0,0,0,0,0, 1, 1, 0,0,0,0,0,0, 0);
      add(0, 0,0,0,0,0,0, 1, 0, 0,0,0,0,0,0, 0);

      // ---- initial reset
      reset = 1'b1; inst_cyc = 0; inst_stb = 0; data_cyc = 0; data_stb = 0;
      data_we = 0; stall = 0;
      repeat (2) @(posedge clk);

      // ---- apply: drive after the edge, queue expectation, compare mid-cycle
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         reset    = vecs[i].rst;
         inst_cyc = vecs[i].ic;  inst_stb = vecs[i].is;
         data_cyc = vecs[i].dc;  data_stb = vecs[i].ds;
         data_we  = vecs[i].dwe; stall    = vecs[i].st;
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL row %0d scoreboard empty", i);
            continue;
         end
         e = exp_q.pop_front();
         d = e.dut;
         exp_ra  = (e.own == 2'd1) ? A_INST : (e.own == 2'd2) ? A_DATA : 32'h0;
         exp_sel = (e.own == 2'd1) ? 4'hF   : (e.own == 2'd2) ? DSEL   : 4'h0;
         check(i, "ram_cyc",  {31'h0, o_rc[d]}, {31'h0, e.rc});
         check(i, "ram_stb",  {31'h0, o_rs[d]}, {31'h0, e.rs});
         check(i, "ram_addr", o_ra[d], exp_ra);
         check(i, "ram_sel",  {28'h0, o_sel[d]}, {28'h0, exp_sel});
         check(i, "ram_we",   {31'h0, o_we[d]}, {31'h0, (e.own == 2'd2) && e.dwe});
         check(i, "inst_ack", {31'h0, o_ia[d]}, {31'h0, e.ia});
         check(i, "data_ack", {31'h0, o_da[d]}, {31'h0, e.da});
         check(i, "inst_err", {31'h0, o_ie[d]}, {31'h0, e.ie});
         check(i, "data_err", {31'h0, o_de[d]}, {31'h0, e.de});
         if (e.rd != 32'h0) begin
            exp_rd = e.ia ? o_ird[d] : o_drd[d];
            check(i, "rdata", exp_rd, e.rd);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
